axis_image_source: RTL
======================

Name: axis_image_source

Overview:
- AXI-Stream image transmitter (master) that synthesises 8-bit grayscale test frames of WIDTH x HEIGHT pixels, BYTES pixels per beat.
- It is the driving end for the image sink path. It feeds a downstream stage such as a pipelined register slice or the image VIP sink in place of the VIP source.
- Generates a programmable number of frames from a selectable pattern. Asserts last on the final beat of each frame.

Parameters:
- BYTES, 4, pixels (bytes) per beat; data width = BYTES*8.
- WIDTH, 8, pixels per line; must be a multiple of BYTES and at least BYTES.
- HEIGHT, 2, lines per frame; at least 1.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous reset, active low.
- start_i  in  1  one-cycle start request; sampled only in IDLE.
- stop_i  in  1  request to stop at the next frame boundary; sampled every cycle in RUN.
- mode_i  in  2  pattern select, latched at start: 0 linear, 1 x-ramp, 2 y-ramp, 3 constant.
- fill_i  in  8  constant pixel value for mode 3, latched at start.
- num_frames_i  in  16  number of frames, latched at start; 0 = continuous until stop.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse when the last frame completes or a stop takes effect.
- axis_m_data_o  out  BYTES*8  pixel data; pixel k of the beat is at bits [8k+7:8k], lowest x in the LSB.
- axis_m_valid_o  out  1  beat valid.
- axis_m_ready_i  in  1  downstream ready.
- axis_m_last_o  out  1  final beat of the frame.

Behaviour:
- Reset: one clock (clk_i); rstn_i is asynchronous and active low. While rstn_i=0, all outputs are 0, state is IDLE, and all counters and latched config are 0. Reset mid-frame abandons the frame; no done_o is issued.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start_i=1. In the same edge, latch mode, fill and num_frames, and clear x, y and the frame counter.
  - In RUN, axis_m_valid_o=1 and busy_o=1, both registered. The first valid appears one cycle after start_i is sampled.
  - start_i is ignored in RUN.
- Counters:
  - x steps by BYTES from 0 to WIDTH-BYTES, then wraps to 0 and increments y.
  - y runs from 0 to HEIGHT-1, then wraps to 0 and increments the frame counter.
  - The frame counter is 16 bits.
  - Counters advance only on handshake (valid && ready).
- Pixel k value, truncated to 8 bits:
  - Mode 0: (y*WIDTH + x + k) mod 256. Restarts at 0 every frame.
  - Mode 1: (x + k) mod 256.
  - Mode 2: y mod 256.
  - Mode 3: fill.
- Last: axis_m_last_o=1 exactly when x=WIDTH-BYTES and y=HEIGHT-1.
- AXIS stability: while valid=1 and ready=0, data and last hold stable. Valid never drops without a handshake.
- Frame end, i.e. handshake on a last beat:
  - If num_frames!=0 and frames completed equals num_frames: go to IDLE, valid=0 in the next cycle, done_o=1 for that cycle.
  - Else if a stop is pending: the same as above.
  - Otherwise the next frame's first beat is valid in the next cycle, with no bubble.
- stop_i: any stop_i=1 in RUN sets a sticky stop_pending flag. The flag takes effect at the end of the current frame. It is cleared on leaving RUN.
- Continuous mode (num_frames=0): the frame counter wraps at 0xFFFF without any effect.
- Throughput: one beat per cycle when ready is held high.

Decomposition:
- Package axis_image_pkg:
  - typedef enum of the pattern modes (PAT_LINEAR, PAT_XRAMP, PAT_YRAMP, PAT_CONST);
  - state typedef (ST_IDLE, ST_RUN);
  - helper localparam BEATS_PER_LINE = WIDTH/BYTES.
- Sub-module axis_image_raster_cnt: x/y/frame counters with an advance input and end-of-line / end-of-frame flags.
- The top level holds the FSM, pattern datapath and output registers.

Test Plan:
- BYTES=4, WIDTH=8, HEIGHT=2, mode 0, num_frames=1, ready=1 -> beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; last only on beat 4; done_o pulses the cycle after beat 4; valid=0 afterwards.
- Mode 1, num_frames=1 -> beats 0x03020100, 0x07060504, 0x03020100, 0x07060504. Mode 2 -> 0x00000000 x2 then 0x01010101 x2.
- Mode 3, fill=0xA5, ready toggling 1,0,0,1,0,1,... -> data 0xA5A5A5A5 and last held stable across every ready=0 cycle; exactly 4 handshakes; done_o after the 4th.
- Mode 0, num_frames=2, ready=1 -> 8 consecutive beats with no bubble; second frame restarts at 0x03020100; last on beats 4 and 8; a single done_o.
- num_frames=0, stop_i pulsed during beat 2 of frame 3 -> frame 3 completes (last on its beat 4); done_o next cycle; busy_o falls; start_i pulsed while busy is ignored.
- rstn_i low asynchronously mid-frame (beat 2, ready=0) -> valid, last, data, busy and done go 0 immediately. After release, a new start yields 0x03020100 first.

Source files
------------

// File: rtl/axis_image_pkg.sv
// Shared types and helpers for the AXI-Stream image source.
package axis_image_pkg;

  localparam int unsigned DEF_BYTES      = 4;
  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_HEIGHT     = 2;
  localparam int unsigned BEATS_PER_LINE = DEF_WIDTH / DEF_BYTES;

  typedef enum logic [1:0] {
    PAT_LINEAR = 2'd0,
    PAT_XRAMP  = 2'd1,
    PAT_YRAMP  = 2'd2,
    PAT_CONST  = 2'd3
  } pat_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_image_raster_cnt.sv
// Raster position counters: x (pixel column, steps by BYTES), y (line), frame.
module axis_image_raster_cnt
  import axis_image_pkg::*;
#(
  parameter int unsigned BYTES  = DEF_BYTES,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned XW     = cnt_width(WIDTH),
  parameter int unsigned YW     = cnt_width(HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clear,
  input  logic          advance,
  output logic [15:0]   frame,
  output logic          eol_c,
  output logic          eof_c,
  output logic          eof_nxt_c,
  output logic [XW-1:0] x_nxt_c,
  output logic [YW-1:0] y_nxt_c
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - BYTES);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // Current-position flags and the position the next advance moves to.
  always_comb begin
    eol_c     = (x == X_LAST);
    eof_c     = eol_c && (y == Y_LAST);
    x_nxt_c   = eol_c ? '0 : x + XW'(BYTES);
    y_nxt_c   = eof_c ? '0 : (eol_c ? y + YW'(1) : y);
    eof_nxt_c = (x_nxt_c == X_LAST) && (y_nxt_c == Y_LAST);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      x     <= '0;
      y     <= '0;
      frame <= '0;
    end else if (clear) begin
      x     <= '0;
      y     <= '0;
      frame <= '0;
    end else if (advance) begin
      x <= x_nxt_c;
      y <= y_nxt_c;
      if (eof_c) frame <= frame + 16'd1;
    end
  end

endmodule

// File: rtl/axis_image_source.sv
// AXI-Stream master generating synthetic 8-bit grayscale frames from a selectable pattern.
module axis_image_source
  import axis_image_pkg::*;
#(
  parameter int unsigned BYTES  = DEF_BYTES,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [1:0]         mode_i,
  input  logic [7:0]         fill_i,
  input  logic [15:0]        num_frames_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BYTES*8-1:0] axis_m_data_o,
  output logic               axis_m_valid_o,
  input  logic               axis_m_ready_i,
  output logic               axis_m_last_o
);

  localparam int unsigned DW = BYTES * 8;
  localparam int unsigned XW = cnt_width(WIDTH);
  localparam int unsigned YW = cnt_width(HEIGHT);
  localparam logic FIRST_LAST = (WIDTH == BYTES) && (HEIGHT == 1);

  state_e      state;
  pat_mode_e   mode_q;
  logic [7:0]  fill_q;
  logic [15:0] num_frames_q;
  logic        stop_pending;

  logic [15:0]   frame;
  logic          eol_c;
  logic          eof_c;
  logic          eof_nxt_c;
  logic [XW-1:0] x_nxt_c;
  logic [YW-1:0] y_nxt_c;
  logic          fire_c;
  logic          finish_c;
  logic          line_wrap_c;

  // Builds one beat of pixels for raster position (xv, yv); pixel k sits in byte k.
  function automatic logic [DW-1:0] make_beat(input pat_mode_e m, input logic [7:0] f,
                                              input logic [XW-1:0] xv, input logic [YW-1:0] yv);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < int'(BYTES); k++) begin
      case (m)
        PAT_LINEAR: d[8*k +: 8] = 8'(32'(yv) * 32'(WIDTH) + 32'(xv) + 32'(k));
        PAT_XRAMP:  d[8*k +: 8] = 8'(32'(xv) + 32'(k));
        PAT_YRAMP:  d[8*k +: 8] = 8'(32'(yv));
        PAT_CONST:  d[8*k +: 8] = f;
        default:    d[8*k +: 8] = 8'd0;
      endcase
    end
    return d;
  endfunction

  axis_image_raster_cnt #(
    .BYTES (BYTES),
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW)
  ) u_raster_cnt (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clear    ((state == ST_IDLE) && start_i),
    .advance  (fire_c),
    .frame    (frame),
    .eol_c    (eol_c),
    .eof_c    (eof_c),
    .eof_nxt_c(eof_nxt_c),
    .x_nxt_c  (x_nxt_c),
    .y_nxt_c  (y_nxt_c)
  );

  // A stop seen in the same cycle as the final handshake still ends the run.
  always_comb begin
    fire_c      = axis_m_valid_o && axis_m_ready_i;
    line_wrap_c = fire_c && eol_c;
    finish_c    = ((num_frames_q != 16'd0) && ((frame + 16'd1) == num_frames_q))
                  || stop_pending || stop_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= ST_IDLE;
      mode_q         <= PAT_LINEAR;
      fill_q         <= '0;
      num_frames_q   <= '0;
      stop_pending   <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      axis_m_valid_o <= 1'b0;
      axis_m_data_o  <= '0;
      axis_m_last_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state          <= ST_RUN;
            mode_q         <= pat_mode_e'(mode_i);
            fill_q         <= fill_i;
            num_frames_q   <= num_frames_i;
            stop_pending   <= 1'b0;
            busy_o         <= 1'b1;
            axis_m_valid_o <= 1'b1;
            axis_m_data_o  <= make_beat(pat_mode_e'(mode_i), fill_i, '0, '0);
            axis_m_last_o  <= FIRST_LAST;
          end
        end
        ST_RUN: begin
          if (stop_i) stop_pending <= 1'b1;
          if (fire_c) begin
            if (eof_c && line_wrap_c && finish_c) begin
              state          <= ST_IDLE;
              stop_pending   <= 1'b0;
              busy_o         <= 1'b0;
              done_o         <= 1'b1;
              axis_m_valid_o <= 1'b0;
              axis_m_data_o  <= '0;
              axis_m_last_o  <= 1'b0;
            end else begin
              axis_m_data_o <= make_beat(mode_q, fill_q, x_nxt_c, y_nxt_c);
              axis_m_last_o <= eof_nxt_c;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
